// File: rtl/shared_reg_pkg.sv
// ----------------------------------------------------------------------------
// shared_reg_pkg
// Shared definitions for the shared-register write arbiter:
//   state_t  - sequencer states (IDLE, SETUP, CAPTURE, ACK), 2-bit encoding
//   CNT_W    - width of the setup-cycle counter
//   MAX_N    - largest supported requester count
//   PTR_W    - width of a requester index / round-robin pointer
//   rr_pick  - round-robin winner selection
// ----------------------------------------------------------------------------
package shared_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam int CNT_W = 4;
    localparam int MAX_N = 8;
    localparam int PTR_W = 3;

    // Returns the index of the first set bit at or above ptr, wrapping.
    // Requests are zero-extended to MAX_N bits, so wrapping modulo MAX_N
    // visits the real requesters in exactly the same order as wrapping
    // modulo the actual requester count.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] win;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dff_en_reg.sv
// ----------------------------------------------------------------------------
// dff_en_reg
// W-bit D flip-flop storage register with synchronous active-high reset and
// a capture enable.
// Ports:
//   i_clk  in  1 : rising-edge clock
//   i_rst  in  1 : synchronous reset, clears the register
//   i_en   in  1 : capture enable
//   i_d    in  W : data input
//   o_q    out W : register contents
// ----------------------------------------------------------------------------
module dff_en_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// shared_reg_arbiter
// Round-robin write arbiter and sequencer for a shared W-bit register. The
// winning requester's data is staged, held on the register D inputs for
// SETUP_CYCLES cycles, captured with a single enable pulse, then acked.
// Ports:
//   clk       in  1   : rising-edge clock
//   rst       in  1   : synchronous active-high reset
//   req       in  N   : per-requester write request (level)
//   wdata     in  N*W : flattened write data, requester i at [i*W +: W]
//   gnt       out N   : one-hot grant, held for the whole transaction
//   ack       out N   : one-cycle completion pulse to the granted requester
//   q         out W   : shared register contents
//   busy      out 1   : high whenever the sequencer is not idle
//   wr_count  out 16  : completed-write counter, wraps
// ----------------------------------------------------------------------------
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N            = 2,
    parameter int W            = 8,
    parameter int SETUP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           busy,
    output logic [15:0]    wr_count
);

    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
            $error("shared_reg_arbiter: SETUP_CYCLES must be in 1..15");
        end
        if (N < 2 || N > MAX_N) begin : g_bad_n
            $error("shared_reg_arbiter: N must be in 2..8");
        end
    endgenerate

    state_t             r_state;
    logic [N-1:0]       r_gnt;
    logic [W-1:0]       r_stage;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [15:0]        r_wr_count;

    logic [MAX_N-1:0]   w_req_ext;
    logic [PTR_W-1:0]   w_win;
    logic               w_en;
    logic [W-1:0]       w_d;
    logic [W-1:0]       w_q;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = req;
    end

    assign w_win = rr_pick(w_req_ext, r_ptr);

    // Sequencer: req and wdata are only looked at in IDLE, so the staged
    // value is frozen for the rest of the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_stage <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt   <= N'(1) << w_win;
                        r_idx   <= w_win;
                        r_stage <= wdata[int'(w_win)*W +: W];
                        r_cnt   <= CNT_W'(SETUP_CYCLES - 1);
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    // Pointer moves past the requester just served.
                    r_ptr   <= (r_idx == PTR_W'(N - 1)) ? '0 : r_idx + PTR_W'(1);
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_count <= '0;
        end else begin
            r_wr_count <= r_wr_count + 16'(r_state == ST_ACK);
        end
    end

    // Outside CAPTURE the register recirculates its own value.
    assign w_en = (r_state == ST_CAPTURE);
    assign w_d  = w_en ? r_stage : w_q;

    dff_en_reg #(
        .W (W)
    ) u_reg (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_en),
        .i_d   (w_d),
        .o_q   (w_q)
    );

    assign gnt      = r_gnt;
    assign ack      = (r_state == ST_ACK) ? r_gnt : '0;
    assign busy     = (r_state != ST_IDLE);
    assign q        = w_q;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_reg_arbiter
// Scoreboard bench for shared_reg_arbiter: a transaction-level model of the
// round-robin arbitration queues expected grants and writes; a separate
// monitor compares them against the outputs on every falling edge.
// ----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

    localparam int N = 3;
    localparam int W = 8;
    localparam int S = 3;

    typedef struct {
        int           cyc;
        logic [N-1:0] oh;
        logic [W-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [15:0]    wr_count;

    shared_reg_arbiter #(
        .N            (N),
        .W            (W),
        .SETUP_CYCLES (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    int n_tests = 0;
    int n_fail  = 0;

    exp_t gq[$];
    exp_t aq[$];
    int   m_ptr       = 0;
    int   next_sample = 0;
    int   b_from      = 0;
    int   b_to        = -1;

    logic [W-1:0]  mon_q   = '0;
    logic [15:0]   mon_cnt = '0;
    logic [N-1:0]  prev_gnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected no such event (cycle %0d)", nm, act, cyc);
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                            input logic [W-1:0] d2);
        return {d2, d1, d0};
    endfunction

    // Applies inputs for the next rising edge and advances the reference model.
    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
        int   e;
        int   w;
        int   idx;
        exp_t it;
        logic [N-1:0] one;
        @(negedge clk);
        #1;
        rst   = r;
        req   = rq;
        wdata = wd;
        e     = cyc + 1;
        one   = 1;
        if (r) begin
            gq.delete();
            aq.delete();
            m_ptr       = 0;
            next_sample = e + 1;
            b_to        = -1;
        end else if (e >= next_sample && rq != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && rq[idx]) w = idx;
            end
            it.cyc  = e;
            it.oh   = one << w;
            it.data = wd[w*W +: W];
            gq.push_back(it);
            it.cyc  = e + S + 1;
            aq.push_back(it);
            b_from      = e;
            b_to        = e + S + 1;
            next_sample = e + S + 3;
            m_ptr       = (w + 1) % N;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, wdata);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            if (rst_s) begin
                chk("rst_gnt", 32'(gnt), 32'h0);
                chk("rst_ack", 32'(ack), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_q", 32'(q), 32'h0);
                chk("rst_wr_count", 32'(wr_count), 32'h0);
                mon_q    = '0;
                mon_cnt  = '0;
                prev_gnt = '0;
            end else begin
                chk("gnt_onehot", 32'(gnt == '0 || $onehot(gnt)), 32'h1);
                chk("ack_without_gnt", 32'(ack & ~gnt), 32'h0);
                chk("busy", 32'(busy), 32'(cyc >= b_from && cyc <= b_to));
                if (gnt != '0 && prev_gnt == '0) begin
                    if (gq.size() == 0) begin
                        flag("unexpected_gnt", 32'(gnt));
                    end else begin
                        e = gq.pop_front();
                        chk("gnt_value", 32'(gnt), 32'(e.oh));
                        chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                    e = gq.pop_front();
                    chk("gnt_missing", 32'(gnt), 32'(e.oh));
                end
                if (ack != '0) begin
                    if (aq.size() == 0) begin
                        flag("unexpected_ack", 32'(ack));
                    end else begin
                        e = aq.pop_front();
                        chk("ack_value", 32'(ack), 32'(e.oh));
                        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                        mon_q = e.data;
                    end
                end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
                    e = aq.pop_front();
                    chk("ack_missing", 32'(ack), 32'(e.oh));
                    mon_q = e.data;
                end
                chk("q", 32'(q), 32'(mon_q));
                chk("wr_count", 32'(wr_count), 32'(mon_cnt));
                if (ack != '0) mon_cnt = mon_cnt + 16'd1;
                prev_gnt = gnt;
            end
        end
    end

    initial begin
        // Reset, then a single write from requester 0
        drive(1'b1, '0, '0);
        drive(1'b1, '0, '0);
        drive(1'b0, 3'b001, pack(8'hA5, 8'h00, 8'h00));
        idle(8);
        chk("single_q", 32'(q), 32'hA5);
        chk("single_count", 32'(wr_count), 32'h1);

        // Contention between requesters 0 and 1 from a fresh pointer
        drive(1'b1, '0, '0);
        for (int i = 0; i < 18; i++) drive(1'b0, 3'b011, pack(8'h11, 8'h22, 8'h00));
        idle(8);

        // Data stability: wdata0 changes while the 0x3C write is in SETUP
        drive(1'b0, 3'b001, pack(8'h3C, 8'h00, 8'h00));
        for (int i = 0; i < 8; i++) drive(1'b0, '0, pack(8'hFF, 8'h00, 8'h00));
        chk("stable_q", 32'(q), 32'h3C);

        // Reset during CAPTURE of a 0x77 write
        drive(1'b1, '0, '0);
        drive(1'b0, 3'b001, pack(8'h77, 8'h00, 8'h00));
        idle(S);
        drive(1'b1, '0, '0);
        idle(6);
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_count", 32'(wr_count), 32'h0);

        // Early release of req0 one cycle after the grant
        drive(1'b0, 3'b001, pack(8'h5A, 8'h00, 8'h00));
        drive(1'b0, 3'b001, pack(8'h5A, 8'h00, 8'h00));
        idle(10);
        chk("release_q", 32'(q), 32'h5A);

        // Counter wrap
        @(negedge clk);
        #1;
        force dut.r_wr_count = 16'hFFFF;
        mon_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_wr_count;
        drive(1'b0, 3'b100, pack(8'h00, 8'h00, 8'hC3));
        idle(8);
        chk("wrap_count", 32'(wr_count), 32'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 149) == 0), N'($urandom_range(0, 7)),
                  pack(8'($urandom), 8'($urandom), 8'($urandom)));
        end
        idle(12);
        chk("drain", 32'(gq.size() + aq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
